// File: rtl/riscv_pipe_ctrl.sv
// Purpose: pipeline sequencing for the 5-stage core (load-use stall, redirect flush, bypass selects, trap drain/halt).
// Latency: stall/bubble/flush/fwd combinational in the same cycle; halted/exception registered, DRAIN_CYCLES+1 after the trap.
// Backpressure: stall_if_id holds IF/ID for one cycle on load-use and permanently once draining/halted.
module riscv_pipe_ctrl #(
  // Cycles allowed for EX/MEM/WB to retire before halting; 1..7 fits the 3-bit counter.
  parameter int DRAIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_we,
  input  logic       id_is_load,
  input  logic       id_sys,
  input  logic       id_ri,
  input  logic       ex_redirect,
  output logic       stall_if_id,
  output logic       bubble_ex,
  output logic       flush_if_id,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       halted,
  output logic       exception
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT} state_t;

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       we;
    logic       load;
  } slot_t;

  localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES);

  state_t     state;
  state_t     state_nxt;
  slot_t      ex_slot;
  slot_t      mem_slot;
  logic [2:0] drain_cnt;
  logic       cause;

  logic       hit_ex_a;
  logic       hit_ex_b;
  logic       hit_mem_a;
  logic       hit_mem_b;
  logic       load_use;
  logic       trap;
  logic       issue;
  logic       stall_c;
  logic       bubble_c;
  logic       flush_c;
  logic [1:0] fwd_a_c;
  logic [1:0] fwd_b_c;

  // A source of x0 never matches, so an rd==0 slot is never a hazard or bypass source.
  assign hit_ex_a  = ex_slot.vld  & ex_slot.we  & (ex_slot.rd  == id_rs1) & (id_rs1 != 5'd0) & id_uses_rs1;
  assign hit_ex_b  = ex_slot.vld  & ex_slot.we  & (ex_slot.rd  == id_rs2) & (id_rs2 != 5'd0) & id_uses_rs2;
  assign hit_mem_a = mem_slot.vld & mem_slot.we & (mem_slot.rd == id_rs1) & (id_rs1 != 5'd0) & id_uses_rs1;
  assign hit_mem_b = mem_slot.vld & mem_slot.we & (mem_slot.rd == id_rs2) & (id_rs2 != 5'd0) & id_uses_rs2;

  assign load_use = id_valid & ex_slot.load & (hit_ex_a | hit_ex_b);
  // A trap behind a load-use stall waits one cycle; a wrong-path trap is discarded.
  assign trap     = id_valid & (id_sys | id_ri) & ~ex_redirect & ~load_use;
  assign issue    = id_valid & ~stall_c & ~bubble_c;

  // Bypass select: EX result beats MEM result; a load in EX cannot forward yet.
  always_comb begin
    fwd_a_c = 2'd0;
    fwd_b_c = 2'd0;
    if (hit_ex_a && !ex_slot.load) fwd_a_c = 2'd1;
    else if (hit_mem_a)            fwd_a_c = 2'd2;
    if (hit_ex_b && !ex_slot.load) fwd_b_c = 2'd1;
    else if (hit_mem_b)            fwd_b_c = 2'd2;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // FSM next-state: RUN -> DRAIN on an accepted trap, DRAIN -> HALT on the last count, HALT terminal.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (trap) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_cnt == 3'd1) state_nxt = ST_HALT;
      default:  state_nxt = ST_HALT;
    endcase
  end

  // FSM outputs: redirect outranks load-use in RUN; DRAIN and HALT freeze the front end.
  always_comb begin
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    flush_c  = 1'b0;
    case (state)
      ST_RUN: begin
        if (ex_redirect) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (load_use) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (trap) begin
          bubble_c = 1'b1;
        end
      end
      default: begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
      end
    endcase
  end

  // Drain counter and trap cause, captured on entry to DRAIN.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      drain_cnt <= 3'd0;
      cause     <= 1'b0;
    end else if (state == ST_RUN && trap) begin
      drain_cnt <= DRAIN_INIT;
      cause     <= id_ri;
    end else if (state == ST_DRAIN) begin
      drain_cnt <= drain_cnt - 3'd1;
    end
  end

  // Shadow scoreboard: MEM follows EX; EX takes the ID instruction only when it issues.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ex_slot  <= '0;
      mem_slot <= '0;
    end else begin
      mem_slot <= ex_slot;
      if (issue) ex_slot <= '{vld: 1'b1, rd: id_rd, we: id_we, load: id_is_load};
      else       ex_slot <= '0;
    end
  end

  // Combinational controls are forced low while reset is held, even with live ID/redirect inputs.
  assign stall_if_id = rst_l & stall_c;
  assign bubble_ex   = rst_l & bubble_c;
  assign flush_if_id = rst_l & flush_c;
  assign fwd_a       = rst_l ? fwd_a_c : 2'd0;
  assign fwd_b       = rst_l ? fwd_b_c : 2'd0;
  assign halted      = (state == ST_HALT);
  assign exception   = (state == ST_HALT) & cause;

endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// Purpose: directed scoreboard bench for riscv_pipe_ctrl (hazards, bypass, redirect, trap drain, reset).
// Latency: inputs driven 1ns after the rising edge, outputs compared on the falling edge of the same cycle.
// Backpressure: none; the stimulus queues expected outputs and the monitor drains them every falling edge.
module tb_riscv_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_l;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [4:0] id_rd;
  logic       id_we;
  logic       id_is_load;
  logic       id_sys;
  logic       id_ri;
  logic       ex_redirect;
  logic       stall_if_id;
  logic       bubble_ex;
  logic       flush_if_id;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       halted;
  logic       exception;

  typedef struct {
    string      name;
    logic [8:0] val;   // {stall, bubble, flush, fwd_a, fwd_b, halted, exception}
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  logic [8:0] act;
  int checks = 0;
  int errors = 0;

  riscv_pipe_ctrl #(.DRAIN_CYCLES(3)) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .id_rd       (id_rd),
    .id_we       (id_we),
    .id_is_load  (id_is_load),
    .id_sys      (id_sys),
    .id_ri       (id_ri),
    .ex_redirect (ex_redirect),
    .stall_if_id (stall_if_id),
    .bubble_ex   (bubble_ex),
    .flush_if_id (flush_if_id),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .halted      (halted),
    .exception   (exception)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic we, input logic ld, input logic sys, input logic ri,
                       input logic redir);
    id_valid    = v;
    id_rs1      = rs1;
    id_uses_rs1 = u1;
    id_rs2      = rs2;
    id_uses_rs2 = u2;
    id_rd       = rd;
    id_we       = we;
    id_is_load  = ld;
    id_sys      = sys;
    id_ri       = ri;
    ex_redirect = redir;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic expect_out(input string nm, input logic st, input logic bu, input logic fl,
                            input logic [1:0] fa, input logic [1:0] fb, input logic h,
                            input logic x);
    exp_t e;
    e.name = nm;
    e.val  = {st, bu, fl, fa, fb, h, x};
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse(input string nm);
    @(posedge clk);
    #3;
    rst_l = 1'b0;
    drive(1, 5, 1, 5, 1, 5, 1, 1, 1, 1, 1);
    expect_out(nm, 0, 0, 0, 2'd0, 2'd0, 0, 0);
    @(negedge clk);
    #2;
    idle();
    rst_l = 1'b1;
  endtask

  // Monitor: compare every queued expectation against the outputs on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        cur = sb_q.pop_front();
        act = {stall_if_id, bubble_ex, flush_if_id, fwd_a, fwd_b, halted, exception};
        checks++;
        if (act !== cur.val) begin
          errors++;
          $display("FAIL %s got=%b want=%b (stall,bubble,flush,fwd_a,fwd_b,halted,exc)",
                   cur.name, act, cur.val);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_l = 1'b0;
    drive(1, 5, 1, 5, 1, 5, 1, 1, 1, 1, 1);
    #1;
    checks++;
    if (halted !== 1'b0 || exception !== 1'b0 || stall_if_id !== 1'b0 || flush_if_id !== 1'b0) begin
      errors++;
      $display("FAIL direct_reset_outputs halted=%b exc=%b stall=%b flush=%b",
               halted, exception, stall_if_id, flush_if_id);
    end
    expect_out("reset_outputs", 0, 0, 0, 2'd0, 2'd0, 0, 0);
    @(negedge clk);
    #2;
    idle();
    rst_l = 1'b1;

    // Load-use: LW x5, then ADD x6,x5 stalls once, then bypasses from MEM.
    step(); drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0); expect_out("lw_x5_issue", 0, 0, 0, 2'd0, 2'd0, 0, 0);
    step(); drive(1, 5, 1, 0, 1, 6, 1, 0, 0, 0, 0); expect_out("load_use_stall", 1, 1, 0, 2'd0, 2'd0, 0, 0);
    step();                                         expect_out("load_use_release_fwd_mem", 0, 0, 0, 2'd2, 2'd0, 0, 0);
    step(); idle();                                 expect_out("idle_after_lu", 0, 0, 0, 2'd0, 2'd0, 0, 0);

    // Bypass priority and x0 handling.
    step(); drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0); expect_out("addi_x7", 0, 0, 0, 2'd0, 2'd0, 0, 0);
    step(); drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0); expect_out("add_x7", 0, 0, 0, 2'd0, 2'd0, 0, 0);
    step(); drive(1, 7, 0, 7, 1, 8, 1, 0, 0, 0, 0); expect_out("fwd_ex_over_mem", 0, 0, 0, 2'd0, 2'd1, 0, 0);
    step(); drive(1, 8, 1, 7, 1, 0, 1, 0, 0, 0, 0); expect_out("fwd_ex_a_mem_b", 0, 0, 0, 2'd1, 2'd2, 0, 0);
    step(); drive(1, 0, 1, 8, 1, 9, 1, 0, 0, 0, 0); expect_out("fwd_rd0_none", 0, 0, 0, 2'd0, 2'd2, 0, 0);

    // Redirect overrides a load-use match and discards a wrong-path ECALL.
    step(); drive(1, 0, 0, 0, 0, 10, 1, 1, 0, 0, 0); expect_out("lw_x10_issue", 0, 0, 0, 2'd0, 2'd0, 0, 0);
    step(); drive(1, 10, 1, 0, 0, 11, 1, 0, 1, 0, 1); expect_out("redirect_over_stall", 0, 1, 1, 2'd0, 2'd0, 0, 0);
    step(); idle();                                   expect_out("after_redirect_run", 0, 0, 0, 2'd0, 2'd0, 0, 0);
    step();                                           expect_out("still_run", 0, 0, 0, 2'd0, 2'd0, 0, 0);

    // ECALL drain: trap at T, drain T+1..T+3 (redirect ignored), halted from T+4.
    step(); drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); expect_out("ecall_trap", 0, 1, 0, 2'd0, 2'd0, 0, 0);
    step(); idle();                                 expect_out("ecall_drain1", 1, 1, 0, 2'd0, 2'd0, 0, 0);
    step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); expect_out("ecall_drain2_redir_ign", 1, 1, 0, 2'd0, 2'd0, 0, 0);
    step(); idle();                                 expect_out("ecall_drain3", 1, 1, 0, 2'd0, 2'd0, 0, 0);
    step();                                         expect_out("ecall_halted", 1, 1, 0, 2'd0, 2'd0, 1, 0);
    checks++;
    if (halted !== 1'b1 || exception !== 1'b0) begin
      errors++;
      $display("FAIL direct_ecall_halted halted=%b exc=%b", halted, exception);
    end
    step(); drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1); expect_out("ecall_halted_sticky", 1, 1, 0, 2'd0, 2'd0, 1, 0);
    step(); idle();                                 expect_out("ecall_halted_sticky2", 1, 1, 0, 2'd0, 2'd0, 1, 0);

    // Illegal instruction behind a load-use stall: stall first, trap next cycle, exception latched.
    reset_pulse("reset_from_halt");
    step(); drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0); expect_out("lw_x3_issue", 0, 0, 0, 2'd0, 2'd0, 0, 0);
    step(); drive(1, 3, 1, 0, 0, 4, 1, 0, 1, 1, 0); expect_out("trap_behind_stall", 1, 1, 0, 2'd0, 2'd0, 0, 0);
    step();                                         expect_out("ri_trap", 0, 1, 0, 2'd2, 2'd0, 0, 0);
    step(); idle();                                 expect_out("ri_drain1", 1, 1, 0, 2'd0, 2'd0, 0, 0);
    step();                                         expect_out("ri_drain2", 1, 1, 0, 2'd0, 2'd0, 0, 0);
    step();                                         expect_out("ri_drain3", 1, 1, 0, 2'd0, 2'd0, 0, 0);
    step();                                         expect_out("ri_halted_exc", 1, 1, 0, 2'd0, 2'd0, 1, 1);
    checks++;
    if (halted !== 1'b1 || exception !== 1'b1) begin
      errors++;
      $display("FAIL direct_ri_halted halted=%b exc=%b", halted, exception);
    end
    step();                                         expect_out("ri_halted_exc_sticky", 1, 1, 0, 2'd0, 2'd0, 1, 1);

    // Reset during drain cycle 2, then a fresh load-use hazard behaves normally.
    reset_pulse("reset_from_halt_exc");
    step(); drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); expect_out("trap_before_mid_reset", 0, 1, 0, 2'd0, 2'd0, 0, 0);
    step(); idle();                                 expect_out("drain1_before_mid_reset", 1, 1, 0, 2'd0, 2'd0, 0, 0);
    reset_pulse("reset_mid_drain_async");
    step(); drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0); expect_out("post_reset_lw", 0, 0, 0, 2'd0, 2'd0, 0, 0);
    step(); drive(1, 0, 0, 5, 1, 6, 1, 0, 0, 0, 0); expect_out("post_reset_stall", 1, 1, 0, 2'd0, 2'd0, 0, 0);
    step();                                         expect_out("post_reset_fwd_mem", 0, 0, 0, 2'd0, 2'd2, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(); idle(); expect_out("post_reset_not_halted", 0, 0, 0, 2'd0, 2'd0, 0, 0);
    end
    checks++;
    if (halted !== 1'b0 || exception !== 1'b0) begin
      errors++;
      $display("FAIL direct_post_reset_not_halted halted=%b exc=%b", halted, exception);
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    if (errors != 0 || checks < 12) $display("FAIL");
    else                            $display("PASS");
    $finish;
  end

endmodule

// File: doc/riscv_pipe_ctrl.md
# riscv_pipe_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. It sits beside the decoder and consumes its per-instruction control outputs (write enable, system, reserved-instruction) plus the register fields. It maintains a shadow scoreboard of destinations in flight in EX and MEM and drives the IF/ID stall, EX bubble, wrong-path flush and operand-bypass selects. It also runs the ECALL/illegal-instruction drain-and-halt sequence.

## Interface
- DRAIN_CYCLES, default 3: cycles to let older instructions (EX, MEM, WB) retire before halting; legal range 1–7.
- clk  in  1  core clock; all state updates on the rising edge.
- rst_l  in  1  reset, asynchronous and active-low.
- id_valid  in  1  decode stage holds a real instruction.
- id_rs1, id_rs2  in  5 each  source register indices of the ID instruction.
- id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction actually reads that source.
- id_rd  in  5  destination index.
- id_we  in  1  decoder write-enable for the ID instruction.
- id_is_load  in  1  ID instruction is LB/LH/LW/LBU/LHU.
- id_sys  in  1  decoder system flag (ECALL).
- id_ri  in  1  decoder reserved/illegal-instruction flag.
- ex_redirect  in  1  taken branch, JAL or JALR resolved in EX this cycle.
- stall_if_id  out  1  hold the PC and the IF/ID register.
- bubble_ex  out  1  load a NOP (we=0) into ID/EX instead of the ID instruction.
- flush_if_id  out  1  invalidate the IF/ID register (wrong path).
- fwd_a, fwd_b  out  2 each  bypass select for rs1/rs2 as the operand enters EX: 0 = register file, 1 = EX result, 2 = MEM result. 3 is never driven.
- halted  out  1  core halted; sticky until reset.
- exception  out  1  halt was caused by an illegal instruction (id_ri), not ECALL; sticky.

## Operation
- Scoreboard: two registered slots, EX and MEM, each holding {valid, rd, we, load}.
  - Every cycle, MEM <= EX.
  - EX <= ID fields when the ID instruction issues (id_valid & ~stall_if_id & ~bubble_ex); otherwise EX <= invalid.
  - A slot with rd==0 never counts as a hazard or bypass source.
- Hazard match: `hit(slot, rs)` = slot.valid & slot.we & slot.rd==rs & rs!=0 & uses_rs.
- Load-use:
  - Condition: hit(EX, rs1 or rs2) with EX.load.
  - Response: stall_if_id=1 and bubble_ex=1.
  - This resolves in exactly 1 cycle, because the load moves to MEM.
- Bypass: fwd_x = 1 if hit(EX, rs_x) and not a load, else 2 if hit(MEM, rs_x), else 0. EX has priority over MEM. Outputs are combinational.
- Redirect priority: ex_redirect=1 forces flush_if_id=1, bubble_ex=1 and stall_if_id=0. This overrides load-use, and the ID instruction is discarded, including any id_sys/id_ri.
- FSM states: RUN, DRAIN, HALT.
  - RUN -> DRAIN: id_valid & (id_sys | id_ri) & ~ex_redirect & ~load-use stall. On entry, load drain counter = DRAIN_CYCLES and latch cause = id_ri (id_ri wins if both flags are set). The trapping instruction itself is not issued (bubble_ex=1).
  - DRAIN: stall_if_id=1, bubble_ex=1, flush_if_id=0, ex_redirect ignored. Counter decrements each cycle. At counter==1 go to HALT.
  - HALT: halted=1, exception=cause, stall_if_id=1, bubble_ex=1. Terminal until rst_l is asserted.
- Reset (asynchronous, any state including mid-DRAIN):
  - State = RUN, counter = 0, scoreboard slots invalid, cause = 0.
  - All outputs 0: stall_if_id, bubble_ex, flush_if_id, fwd_a, fwd_b, halted, exception.

## Timing
- stall_if_id, bubble_ex, flush_if_id and fwd_* are combinational from inputs plus registered state, valid in the same cycle.
- halted and exception are registered outputs.
- Load-use penalty: 1 cycle. Redirect penalty: 2 instructions squashed (IF/ID flushed and ID bubbled in the same cycle).
- Halt latency: the trap is in ID in cycle T. DRAIN covers cycles T+1 .. T+DRAIN_CYCLES. halted=1 from cycle T+DRAIN_CYCLES+1 onward.
- With id_valid=0, no stall or trap is raised regardless of the other ID inputs.
- Simultaneous load-use and trap: stall first. The trap is taken on the following cycle, when the stall clears.

## Test plan
- Load-use stall: LW x5 in EX (EX.load=1, rd=5); ID reads rs1=5 -> stall_if_id=1 and bubble_ex=1 for exactly 1 cycle. Next cycle fwd_a=2.
- Bypass priority: ADD x7 in EX and ADDI x7 in MEM; ID reads rs2=7 -> fwd_b=1. With EX.rd=0 or rd=x0 as source -> fwd=0.
- Redirect over stall: ex_redirect=1 in the same cycle as a load-use match -> flush_if_id=1, bubble_ex=1, stall_if_id=0. The wrong-path id_sys=1 is ignored and the FSM stays in RUN.
- ECALL drain: DRAIN_CYCLES=3, id_sys=1 at cycle 10 -> stall_if_id=1 for cycles 11–13, halted=1 from cycle 14, exception=0. Both stay set indefinitely.
- Illegal instruction: id_ri=1 with id_sys=1 -> halted=1 after the drain and exception=1.
- Reset mid-DRAIN: drop rst_l at drain cycle 2 -> all outputs 0 immediately (asynchronous). After release, a fresh LW hazard still stalls correctly and halted stays 0.
